// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file writeback port arbiter with a one-deep registered output stage
// Optional RF_WB_ARB_ROUND_ROBIN_EN selects round-robin; the default build uses fixed priority (lowest index wins).
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              we3,
    output logic [AW-1:0]     wa3,
    output logic [DW-1:0]     wd3,
    output logic [2:0]        gnt_id
);

    logic          grant;
    logic [2:0]    win_idx;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

`ifdef RF_WB_ARB_ROUND_ROBIN_EN
    logic [2:0] rr_ptr;
    logic [2:0] hi_idx;
    logic [2:0] lo_idx;
    logic       hi_found;

    // Winner is the lowest valid index at or above rr_ptr, else the lowest valid overall (wrap).
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = 3'(i);
                if (3'(i) >= rr_ptr) begin
                    hi_idx   = 3'(i);
                    hi_found = 1'b1;
                end
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_idx = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        grant     = (|req_valid) & ~stall & ~reset;
        req_ready = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == 3'(i)) begin
                req_ready[i] = grant;
                sel_addr     = req_addr[i*AW +: AW];
                sel_data     = req_data[i*DW +: DW];
            end
        end
    end

    // x0 writes still complete the handshake but never raise we3.
    always_ff @(posedge clk) begin
        if (reset) begin
            we3    <= 1'b0;
            wa3    <= '0;
            wd3    <= '0;
            gnt_id <= '0;
        end else if (grant) begin
            we3    <= (sel_addr != '0);
            wa3    <= sel_addr;
            wd3    <= sel_data;
            gnt_id <= win_idx;
        end else begin
            we3    <= 1'b0;
        end
    end

endmodule
